// File: rtl/memory_region_router_if.sv
// memory_region_router bus bundle
// CPU memory-stage side and region-target side in one interface
interface memory_region_router_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SEL_W  = 2
);
  localparam int NR = 1 << SEL_W;

  logic                     MR_i;
  logic                     MW_i;
  logic [ADDR_W-1:0]        address_i;
  logic [DATA_W-1:0]        data_i;
  logic [DATA_W-1:0]        data_o;
  logic                     stall_o;
  logic                     done_o;
  logic                     err_o;
  logic [NR-1:0]            req_o;
  logic                     we_o;
  logic [ADDR_W-SEL_W-1:0]  addr_o;
  logic [DATA_W-1:0]        wdata_o;
  logic [NR-1:0]            ack_i;
  logic [NR*DATA_W-1:0]     rdata_i;

  modport slave (
    input  MR_i, MW_i, address_i, data_i,
    input  ack_i, rdata_i,
    output data_o, stall_o, done_o, err_o,
    output req_o, we_o, addr_o, wdata_o
  );

  modport master (
    output MR_i, MW_i, address_i, data_i,
    output ack_i, rdata_i,
    input  data_o, stall_o, done_o, err_o,
    input  req_o, we_o, addr_o, wdata_o
  );
endinterface

// File: rtl/memory_region_router.sv
// memory_region_router: decodes CPU accesses into regions,
// runs req/ack with the target, stalls CPU, returns read data
module memory_region_router #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SEL_W  = 2,
  parameter logic [(1<<SEL_W)-1:0] REGION_EN = '1,
  parameter int TIMEOUT = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  memory_region_router_if.slave bus
);
  localparam int NR = 1 << SEL_W;
  localparam int AW = ADDR_W - SEL_W;
  localparam int CW = (TIMEOUT > 0) ?
                      $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state;
  logic [SEL_W-1:0]  sel;
  logic              we;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] data;
  logic              err;
  logic [CW-1:0]     cnt;

  logic [SEL_W-1:0]  sel_in;
  logic              cpu_req;
  logic              ack_sel;
  logic              expire;
  logic [DATA_W-1:0] rdata_sel;

  assign sel_in    = bus.address_i[ADDR_W-1 -: SEL_W];
  assign cpu_req   = bus.MR_i | bus.MW_i;
  assign ack_sel   = bus.ack_i[sel];
  assign rdata_sel = bus.rdata_i[int'(sel)*DATA_W +: DATA_W];
  assign expire    = (TIMEOUT != 0) && (cnt == TLAST);

  assign bus.stall_o = ((state == S_IDLE) & cpu_req)
                     | (state == S_ACCESS);
  assign bus.req_o   = (state == S_ACCESS) ?
                       (NR'(1) << sel) : '0;
  assign bus.done_o  = (state == S_RESP);
  assign bus.err_o   = (state == S_RESP) & err;
  assign bus.we_o    = we;
  assign bus.addr_o  = addr;
  assign bus.wdata_o = wdata;
  assign bus.data_o  = data;

  // Transaction FSM, latched bus fields, timeout counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
      sel   <= '0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      data  <= '0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            if (REGION_EN[sel_in]) begin
              sel   <= sel_in;
              we    <= bus.MW_i;
              addr  <= bus.address_i[AW-1:0];
              wdata <= bus.data_i;
              cnt   <= '0;
              err   <= 1'b0;
              state <= S_ACCESS;
            end else begin
              err   <= 1'b1;
              if (!bus.MW_i) data <= ERR_DATA;
              state <= S_RESP;
            end
          end
        end
        S_ACCESS: begin
          if (ack_sel) begin
            if (!we) data <= rdata_sel;
            err   <= 1'b0;
            state <= S_RESP;
          end else if (expire) begin
            if (!we) data <= ERR_DATA;
            err   <= 1'b1;
            state <= S_RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/memory_region_router.md
Name: memory_region_router

Overview:
- Sequential, parametrised successor to the combinational memory manager.
- Decodes the CPU load/store address into 2^SEL_W regions (main memory, sprite memory, UART, …).
- Runs a req/ack handshake with the selected target, stalls the CPU until the access completes, and returns registered read data.
- Adds per-region enable, access timeout and error reporting.
- Sits between the CPU datapath memory stage and the memory/peripheral slaves.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, CPU address width.
- SEL_W, 2, region-select bits taken from address MSBs; NR = 2^SEL_W regions.
- REGION_EN, {NR{1'b1}}, bitmask of regions that exist; access to a cleared bit is an error.
- TIMEOUT, 15, max ACCESS cycles waiting for ack; 0 = wait forever.
- ERR_DATA, 32'hDEADBEEF, value loaded into data_o on an errored read.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- MR_i  in  1  CPU memory read
- MW_i  in  1  CPU memory write
- address_i  in  ADDR_W  CPU byte address
- data_i  in  DATA_W  CPU write data
- data_o  out  DATA_W  registered read data
- stall_o  out  1  CPU must hold its request while high
- done_o  out  1  one-cycle completion strobe
- err_o  out  1  error qualifier, valid with done_o
- req_o  out  NR  one-hot request to the selected region
- we_o  out  1  write enable to targets, shared
- addr_o  out  ADDR_W-SEL_W  latched address[ADDR_W-SEL_W-1:0], shared
- wdata_o  out  DATA_W  latched write data, shared
- ack_i  in  NR  per-region completion
- rdata_i  in  NR*DATA_W  per-region read data; region k at [k*DATA_W +: DATA_W]

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - State IDLE, counter 0.
  - req_o=0, we_o=0, addr_o=0, wdata_o=0, data_o=0, done_o=0, err_o=0.
  - Any in-flight request is dropped immediately; ack_i after reset is ignored.
- Region decode: sel = address_i[ADDR_W-1 -: SEL_W]. Defaults: 0x0…→0, 0x4…→1, 0x8…→2, 0xC…→3.
- MR_i=MW_i=1: treated as a write (MW priority); the read is not performed.
- stall_o (combinational) = (IDLE & (MR_i|MW_i)) | ACCESS. It is low in RESP.
- FSM states IDLE, ACCESS, RESP:
  - IDLE, no request: stay.
  - IDLE, request to an enabled region: latch sel, we=MW_i, addr_o, wdata_o; reset counter; go to ACCESS.
  - IDLE, request to a disabled region: no req_o is issued; latch err; go to RESP (one-cycle error path).
  - ACCESS: req_o[sel]=1 and held steady with we_o/addr_o/wdata_o; counter increments each cycle.
  - ACCESS, ack_i[sel]=1: if a read, data_o <= rdata_i[sel]; go to RESP. ack_i of non-selected regions is ignored.
  - ACCESS, TIMEOUT!=0 and counter==TIMEOUT-1 with no ack: latch err; if a read, data_o <= ERR_DATA; go to RESP.
  - ACCESS, ack and timeout expiry in the same cycle: ack wins, no error.
  - RESP: done_o=1, err_o=latched err, req_o=0. CPU inputs are ignored this cycle. Next state is IDLE.
- Latency, zero-wait target (ack in first ACCESS cycle): request cycle + 1 ACCESS + RESP, so stall_o is high for 2 cycles.
- data_o holds its value across writes and idle cycles. It changes only on read completion or read error.
- Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- A request still asserted in IDLE after RESP is a new transaction. De-asserting it is the CPU's job.

Test Plan:
1. Zero-wait read: MR_i=1, address_i=0x0000FFFF, region 0 acks on first ACCESS cycle with rdata=0xCCCCCCCC.
   -> req_o=4'b0001, addr_o=0x0000FFFF, stall_o high 2 cycles, done_o pulse, data_o=0xCCCCCCCC, err_o=0.
2. Wait-state write: MW_i=1, address_i=0x8000FFFF, data_i=0xF0F0F0F0, region 2 acks after 3 cycles.
   -> req_o=4'b0100 for 3 cycles, we_o=1, wdata_o=0xF0F0F0F0, data_o unchanged, done_o after ack.
3. MR_i=MW_i=1 to 0xC000FFFF, region 3 acks.
   -> we_o=1, req_o=4'b1000, data_o unchanged.
4. Timeout: TIMEOUT=15, read to region 1 with no ack.
   -> req_o[1] high exactly 15 cycles, then done_o=1 and err_o=1, data_o=0xDEADBEEF.
   Repeat with ack on cycle 15 -> no error.
5. REGION_EN=4'b1101, read to 0x4000_0000.
   -> req_o stays 0, done_o and err_o the cycle after the request, stall_o high for 1 cycle.
6. rst_n_i pulsed low mid-ACCESS.
   -> req_o, stall_o, done_o drop without waiting for a clock edge; a later ack_i is ignored; the next request starts cleanly.
